// File: rtl/fpu_utils_norm_pipe_pkg.sv
// Shared types and defaults for the FPU leading-zero normalizer slice.
package fpu_utils_norm_pipe_pkg;

    localparam int DATA_WIDTH_DEF  = 77;
    localparam int SHAMT_WIDTH_DEF = 7;
    localparam int EXP_WIDTH_DEF   = 13;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]  data;
        logic [EXP_WIDTH_DEF-1:0]   exp;
        logic [SHAMT_WIDTH_DEF-1:0] max_shamt;
    } norm_req_t;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]  data;
        logic [EXP_WIDTH_DEF-1:0]   exp;
        logic [SHAMT_WIDTH_DEF-1:0] shamt;
        logic                       zero;
        logic                       tiny;
    } norm_rsp_t;

endpackage

// File: rtl/fpu_utils_barrel_shift.sv
// Logarithmic barrel shifter; LEFT selects shift direction, vacated bits are zero-filled.
module fpu_utils_barrel_shift #(
    parameter int DATA_WIDTH  = 77,
    parameter int SHAMT_WIDTH = 7,
    parameter bit LEFT        = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic [DATA_WIDTH-1:0]  data_o
);

    logic [SHAMT_WIDTH:0][DATA_WIDTH-1:0] stg;

    assign stg[0] = data_i;

    for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
        if (LEFT) begin : g_left
            assign stg[k+1] = shamt_i[k] ? (stg[k] << (1 << k)) : stg[k];
        end else begin : g_right
            assign stg[k+1] = shamt_i[k] ? (stg[k] >> (1 << k)) : stg[k];
        end
    end

    assign data_o = stg[SHAMT_WIDTH];

endmodule

// File: rtl/fpu_utils_lzc.sv
// Combinational leading-zero counter; cnt = DATA_WIDTH when the input is all zeros.
module fpu_utils_lzc
    import fpu_utils_norm_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic [SHAMT_WIDTH-1:0] cnt_o,
    output logic                   all_zero_o
);

    // Priority scan from the LSB upward: the highest set bit writes last and wins.
    always_comb begin
        cnt_o      = SHAMT_WIDTH'(DATA_WIDTH);
        all_zero_o = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o      = SHAMT_WIDTH'(DATA_WIDTH - 1 - i);
                all_zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fpu_utils_norm_pipe.sv
// Two-stage leading-zero normalizer: stage 1 counts and clamps, stage 2 shifts and adjusts the exponent.
module fpu_utils_norm_pipe
    import fpu_utils_norm_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF,
    parameter int EXP_WIDTH   = EXP_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [EXP_WIDTH-1:0]   exp_i,
    input  logic [SHAMT_WIDTH-1:0] max_shamt_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [EXP_WIDTH-1:0]   exp_o,
    output logic [SHAMT_WIDTH-1:0] shamt_o,
    output logic                   zero_o,
    output logic                   tiny_o
);

    // vld_pipe_q[1] is stage 1 occupancy, vld_pipe_q[2] is stage 2 (the output).
    logic [2:1] vld_pipe_q, vld_pipe_d;

    logic s2_ready, accept, advance;

    assign s2_ready = !vld_pipe_q[2] || ready_i;
    assign ready_o  = !vld_pipe_q[1] || s2_ready;
    assign accept   = valid_i && ready_o;
    assign advance  = vld_pipe_q[1] && s2_ready;
    assign valid_o  = vld_pipe_q[2];

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (advance)      vld_pipe_d[1] = 1'b0;
        if (accept)       vld_pipe_d[1] = 1'b1;
        if (ready_i)      vld_pipe_d[2] = 1'b0;
        if (advance)      vld_pipe_d[2] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_pipe_q <= '0;
        else         vld_pipe_q <= vld_pipe_d;
    end

    // ---------------- stage 1: count and clamp ----------------
    logic [SHAMT_WIDTH-1:0] lzc;
    logic                   in_zero;

    fpu_utils_lzc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_lzc (
        .data_i     (data_i),
        .cnt_o      (lzc),
        .all_zero_o (in_zero)
    );

    logic [SHAMT_WIDTH-1:0] sh_d;
    logic                   tiny_d;

    always_comb begin
        sh_d   = '0;
        tiny_d = 1'b0;
        if (!in_zero) begin
            if (lzc > max_shamt_i) begin
                sh_d   = max_shamt_i;
                tiny_d = 1'b1;
            end else begin
                sh_d   = lzc;
            end
        end
    end

    logic [DATA_WIDTH-1:0]  s1_data_q;
    logic [EXP_WIDTH-1:0]   s1_exp_q;
    logic [SHAMT_WIDTH-1:0] s1_sh_q;
    logic                   s1_zero_q, s1_tiny_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_data_q <= '0;
            s1_exp_q  <= '0;
            s1_sh_q   <= '0;
            s1_zero_q <= 1'b0;
            s1_tiny_q <= 1'b0;
        end else if (accept) begin
            s1_data_q <= data_i;
            s1_exp_q  <= exp_i;
            s1_sh_q   <= sh_d;
            s1_zero_q <= in_zero;
            s1_tiny_q <= tiny_d;
        end
    end

    // ---------------- stage 2: shift and adjust exponent ----------------
    logic [DATA_WIDTH-1:0] shifted;
    logic [EXP_WIDTH-1:0]  exp_d;

    fpu_utils_barrel_shift #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH),
        .LEFT        (1'b1)
    ) u_shift (
        .data_i  (s1_data_q),
        .shamt_i (s1_sh_q),
        .data_o  (shifted)
    );

    assign exp_d = s1_exp_q - {{(EXP_WIDTH-SHAMT_WIDTH){1'b0}}, s1_sh_q};

    logic [DATA_WIDTH-1:0]  data_q;
    logic [EXP_WIDTH-1:0]   exp_q;
    logic [SHAMT_WIDTH-1:0] shamt_q;
    logic                   zero_q, tiny_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            exp_q   <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            tiny_q  <= 1'b0;
        end else if (advance) begin
            data_q  <= shifted;
            exp_q   <= exp_d;
            shamt_q <= s1_sh_q;
            zero_q  <= s1_zero_q;
            tiny_q  <= s1_tiny_q;
        end
    end

    assign data_o  = data_q;
    assign exp_o   = exp_q;
    assign shamt_o = shamt_q;
    assign zero_o  = zero_q;
    assign tiny_o  = tiny_q;

endmodule

// File: doc/fpu_utils_norm_pipe.md
Name: fpu_utils_norm_pipe

Overview:
- Pipelined leading-zero normalizer for the FPU datapath; it is the inverse of a shift-by-amount utility.
- It derives the shift amount from the data, left-shifts the mantissa so its MSB is 1, and adjusts the exponent to match.
- It sits after the adder/FMA mantissa sum and before the rounder.
- The shift is clamped by a caller-supplied limit so that subnormal results stop at the minimum exponent.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 77: mantissa width, in and out.
- SHAMT_WIDTH, 7: shift-amount width. Must satisfy 2^SHAMT_WIDTH > DATA_WIDTH.
- EXP_WIDTH, 13: signed exponent width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  upstream request valid.
- ready_o  out  1  block can accept the request this cycle.
- data_i  in  DATA_WIDTH  unnormalized mantissa.
- exp_i  in  EXP_WIDTH  signed exponent paired with data_i.
- max_shamt_i  in  SHAMT_WIDTH  largest allowed left shift (exp_i − EXP_MIN, computed by the caller).
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- data_o  out  DATA_WIDTH  normalized mantissa.
- exp_o  out  EXP_WIDTH  exp_i − shamt_o, two's complement, wraps modulo 2^EXP_WIDTH.
- shamt_o  out  SHAMT_WIDTH  shift actually applied.
- zero_o  out  1  data_i was all zeros.
- tiny_o  out  1  lzc > max_shamt_i, with data nonzero; the shift was clamped.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - both stage-valid flags clear, so valid_o=0 and ready_o=1;
  - data_o, exp_o, shamt_o, zero_o, tiny_o reset to 0.
  - Assertion mid-operation discards all in-flight items immediately. No partial output follows release.
- Stage 1, registered on acceptance (valid_i && ready_o):
  - lzc = number of leading zeros of data_i; DATA_WIDTH when data_i == 0;
  - sh = min(lzc, max_shamt_i);
  - capture data_i, exp_i, sh, zero = (data_i == 0), tiny = (!zero && lzc > max_shamt_i).
- Stage 2, registered when stage 1 advances:
  - data_o = s1_data << s1_sh, zero-filled from the LSB, bits shifted past the MSB dropped;
  - exp_o = s1_exp − zero-extended s1_sh;
  - shamt_o = s1_sh.
- Zero input:
  - sh forced to 0, so data_o=0 and exp_o=exp_i;
  - zero_o=1, tiny_o=0.
- Latency is exactly 2 cycles from acceptance to valid_o when ready_i=1. Throughput is 1 per cycle.
- Handshake:
  - s2_ready = !s2_valid || ready_i;
  - ready_o = !s1_valid || s2_ready;
  - stage 1 advances into stage 2 iff s1_valid && s2_ready.
  - Combinational ready chain; no skid buffer.
  - While valid_o && !ready_i, every output holds stable.
  - An accept in the same cycle as a downstream pop refills the pipeline without a bubble.
  - valid_i may drop without being accepted. Data is sampled only on acceptance.
- Boundaries:
  - max_shamt_i = 0 passes data through unshifted; tiny_o=1 if the MSB is 0.
  - max_shamt_i ≥ DATA_WIDTH never clamps a nonzero input.
  - MSB already set gives sh=0, tiny_o=0.
  - Full pipeline with ready_i=0 gives ready_o=0 after both stages fill.

Decomposition:
- Shared FPU package:
  - typedef norm_req_t {data, exp, max_shamt};
  - typedef norm_rsp_t {data, exp, shamt, zero, tiny};
  - constants DATA_WIDTH_DEF=77, SHAMT_WIDTH_DEF=7.
- Sub-module fpu_utils_lzc: combinational leading-zero counter with a tree/priority structure, parameterized by DATA_WIDTH/SHAMT_WIDTH, outputs {cnt, all_zero}.
- The stage-2 shift instantiates the team's existing barrel shifter utility in left mode.

Test Plan:
1. data_i=1<<40, exp_i=100, max_shamt_i=127, ready_i=1 → two cycles later: valid_o=1, data_o=1<<76, shamt_o=36, exp_o=64, zero_o=0, tiny_o=0.
2. data_i=0, exp_i=−5 → data_o=0, shamt_o=0, exp_o=−5, zero_o=1, tiny_o=0.
3. data_i=1<<10, exp_i=20, max_shamt_i=20 → clamped: shamt_o=20, data_o=1<<30, exp_o=0, tiny_o=1.
4. Back-to-back valid_i for 8 cycles, ready_i=1, inputs 1<<0..1<<7 → 8 consecutive results, shamt_o=76..69, no bubbles, in order.
5. Fill the pipeline with ready_i=0 → ready_o falls after 2 accepts and outputs stay stable; pulse ready_i=1 for 1 cycle → one result pops and ready_o=1 the same cycle.
6. Assert rst_ni low with 2 items in flight → valid_o=0 and ready_o=1 immediately, with no output after release.
